// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory read port, decode handshake,
// and the redirect/halt controls coming back from downstream.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              ins_valid;
    logic [DATA_W-1:0] ins_data;
    logic [ADDR_W-1:0] ins_pc;
    logic              ins_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;

    modport master (
        output imem_req, imem_addr, ins_valid, ins_data, ins_pc,
        input  imem_data, ins_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr, ins_valid, ins_data, ins_pc,
        output imem_data, ins_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads ins_mem one request at a time,
// and queues PC-tagged instructions for decode with redirect/halt support.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned QDEPTH = 2
) (
    input logic                clk,
    input logic                reset,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam int unsigned PTR_W = $clog2(QDEPTH);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tag;
    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [DATA_W-1:0] q_data [QDEPTH];
    logic [ADDR_W-1:0] q_pc   [QDEPTH];

    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W:0]    occ;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(QDEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Occupancy counts the slot reserved by the outstanding request, so the
    // queue can never be overrun by a response.
    always_comb begin
        pop   = (count != '0) & bus.ins_ready;
        push  = inflight & ~bus.redirect;
        occ   = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
        issue = ~reset & ~bus.halt & ~bus.redirect & (occ < (CNT_W+1)'(QDEPTH));
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc;
    assign bus.ins_valid = (count != '0);
    assign bus.ins_data  = q_data[rd_ptr];
    assign bus.ins_pc    = q_pc[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= '0;
            tag      <= '0;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (bus.redirect) begin
            pc       <= bus.redirect_pc;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc  <= pc + 1'b1;
                tag <= pc;
            end
            if (push) begin
                q_data[wr_ptr] <= bus.imem_data;
                q_pc[wr_ptr]   <= tag;
                wr_ptr         <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (reset) !(push && count == CNT_W'(QDEPTH))
    );
endmodule
